// File: rtl/cmn_weighted_rr_arb_if.sv
// Request/grant handshake bundle between requesters and cmn_weighted_rr_arb.
// master = requester/downstream side, slave = arbiter side.
interface cmn_weighted_rr_arb_if #(
  parameter int unsigned p_num_reqs = 4
);
  localparam int unsigned ID_W = $clog2(p_num_reqs);

  logic [p_num_reqs-1:0] reqs;
  logic [p_num_reqs-1:0] locks;
  logic                  out_rdy;
  logic [p_num_reqs-1:0] grants;
  logic [ID_W-1:0]       grant_id;
  logic                  xfer;
  logic                  locked;

  modport master (
    output reqs, locks, out_rdy,
    input  grants, grant_id, xfer, locked
  );

  modport slave (
    input  reqs, locks, out_rdy,
    output grants, grant_id, xfer, locked
  );
endinterface

// File: rtl/cmn_weighted_rr_arb.sv
// N-way arbiter: fixed priority or weighted round-robin, with packet locking
// and a grant that is held stable while downstream is not ready.
module cmn_weighted_rr_arb #(
  parameter int unsigned p_num_reqs    = 4,
  parameter int unsigned p_weight_bits = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode,
  input  logic [p_num_reqs*p_weight_bits-1:0] weights,
  cmn_weighted_rr_arb_if.slave                bus
);
  localparam int unsigned N    = p_num_reqs;
  localparam int unsigned W    = p_weight_bits;
  localparam int unsigned ID_W = $clog2(N);

  logic [N-1:0]    prio;
  logic [N-1:0]    owner;
  logic            owner_val;
  logic            hold;
  logic            locked;
  logic [W-1:0]    credit;

  logic [N-1:0]    owner_req;
  logic [N-1:0]    rr_start;
  logic [N-1:0]    rr_pick;
  logic [N-1:0]    grants;
  logic [ID_W-1:0] grant_id;
  logic            drop;
  logic            is_new;
  logic            xfer;
  logic            found;
  int unsigned     start_idx;
  logic [W-1:0]    w_g;
  logic [W-1:0]    eff_w;
  logic [W-1:0]    next_cnt;

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  always_comb begin
    owner_req = owner & bus.reqs;
    // Owner walked away from an unlocked hold/burst: release it and let
    // rule-4 arbitration pick someone else in this very cycle.
    drop = !locked && (hold || owner_val) && (owner_req == '0);

    if (!mode)     rr_start = N'(1);
    else if (drop) rr_start = rotl1(owner);
    else           rr_start = prio;

    start_idx = 0;
    for (int unsigned s = 0; s < N; s++)
      if (rr_start[s]) start_idx = s;

    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && bus.reqs[ID_W'((start_idx + i) % N)]) begin
        rr_pick[ID_W'((start_idx + i) % N)] = 1'b1;
        found = 1'b1;
      end
    end

    if (locked)
      grants = owner_req;
    else if (!drop && (hold || (owner_val && credit != '0)))
      grants = owner;
    else
      grants = rr_pick;

    grant_id = '0;
    w_g      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grants[i]) begin
        grant_id = ID_W'(i);
        w_g      = weights[i*W +: W];
      end
    end

    xfer     = (|grants) && bus.out_rdy;
    // A grant is fresh unless it continues a locked packet or a live burst.
    is_new   = !locked && (!owner_val || drop);
    eff_w    = (!mode || w_g == '0) ? W'(1) : w_g;
    next_cnt = (is_new ? eff_w : credit) - W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio      <= N'(1);
      owner     <= '0;
      owner_val <= 1'b0;
      hold      <= 1'b0;
      locked    <= 1'b0;
      credit    <= '0;
    end else begin
      if (drop) begin
        owner_val <= 1'b0;
        hold      <= 1'b0;
        credit    <= '0;
        prio      <= rotl1(owner);
      end
      if (xfer) begin
        hold  <= 1'b0;
        owner <= grants;
        if (bus.locks[grant_id]) begin
          locked <= 1'b1;
          if (is_new) credit <= eff_w;
        end else begin
          locked <= 1'b0;
          if (next_cnt != '0) begin
            owner_val <= 1'b1;
            credit    <= next_cnt;
          end else begin
            owner_val <= 1'b0;
            credit    <= '0;
            prio      <= rotl1(grants);
          end
        end
      end else if (|grants) begin
        hold  <= 1'b1;
        owner <= grants;
      end
    end
  end

  assign bus.grants   = grants;
  assign bus.grant_id = grant_id;
  assign bus.xfer     = xfer;
  assign bus.locked   = locked;
endmodule

// File: tb/tb_cmn_weighted_rr_arb.sv
// Directed bench for cmn_weighted_rr_arb (4 requesters, 4-bit weights).
module tb_cmn_weighted_rr_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [15:0] weights;
  int          n_tests = 0;
  int          n_fail  = 0;

  cmn_weighted_rr_arb_if #(.p_num_reqs(4)) bus ();

  cmn_weighted_rr_arb #(.p_num_reqs(4), .p_weight_bits(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .weights (weights),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    bus.reqs  = '0;
    bus.locks = '0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int e1[5] = '{0, 1, 2, 3, 0};
    int e2[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    reset       = 1'b0;
    mode        = 1'b1;
    weights     = 16'h1111;
    bus.reqs    = '0;
    bus.locks   = '0;
    bus.out_rdy = 1'b1;
    #2;
    chk("rst_grants", 32'(bus.grants), 0);
    chk("rst_gid",    32'(bus.grant_id), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_xfer",   32'(bus.xfer), 0);
    step();
    reset = 1'b1;

    // plain round robin
    bus.reqs = 4'b1111;
    #1;
    chk("t1_grants0", 32'(bus.grants), 32'h1);
    chk("t1_xfer0",   32'(bus.xfer), 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_gid%0d", i), 32'(bus.grant_id), 32'(e1[i]));
      step();
    end

    // weighted burst w0=3, w1=1
    do_reset();
    weights  = 16'h1113;
    bus.reqs = 4'b0011;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_gid%0d", i), 32'(bus.grant_id), 32'(e2[i]));
      step();
    end

    // 4-beat packet from req0 is not split
    do_reset();
    weights   = 16'h1111;
    bus.reqs  = 4'b0011;
    bus.locks = 4'b0001;
    #1;
    chk("t3_gid_c1", 32'(bus.grant_id), 0);
    chk("t3_lock_c1", 32'(bus.locked), 0);
    step();
    chk("t3_gid_c2", 32'(bus.grant_id), 0);
    chk("t3_lock_c2", 32'(bus.locked), 1);
    step();
    chk("t3_gid_c3", 32'(bus.grant_id), 0);
    chk("t3_lock_c3", 32'(bus.locked), 1);
    step();
    bus.locks = 4'b0000;
    #1;
    chk("t3_gid_c4", 32'(bus.grant_id), 0);
    chk("t3_lock_c4", 32'(bus.locked), 1);
    step();
    chk("t3_gid_c5", 32'(bus.grant_id), 1);
    chk("t3_lock_c5", 32'(bus.locked), 0);

    // grant held while out_rdy is low
    do_reset();
    bus.reqs    = 4'b0100;
    bus.out_rdy = 1'b0;
    #1;
    chk("t4_grants_c1", 32'(bus.grants), 32'h4);
    chk("t4_xfer_c1",   32'(bus.xfer), 0);
    step();
    bus.reqs = 4'b0101;
    #1;
    chk("t4_grants_c2", 32'(bus.grants), 32'h4);
    chk("t4_xfer_c2",   32'(bus.xfer), 0);
    step();
    chk("t4_grants_c3", 32'(bus.grants), 32'h4);
    bus.out_rdy = 1'b1;
    #1;
    chk("t4_grants_c4", 32'(bus.grants), 32'h4);
    chk("t4_xfer_c4",   32'(bus.xfer), 1);
    step();
    chk("t4_grants_c5", 32'(bus.grants), 32'h1);

    // fixed priority ignores weights
    do_reset();
    mode     = 1'b0;
    weights  = 16'hFFFF;
    bus.reqs = 4'b1010;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_grants%0d", i), 32'(bus.grants), 32'h2);
      step();
    end
    bus.reqs = 4'b1000;
    #1;
    chk("t5_drop", 32'(bus.grants), 32'h8);

    // burst owner drops request: another wins the same cycle
    do_reset();
    mode     = 1'b1;
    weights  = 16'h1113;
    bus.reqs = 4'b0011;
    #1;
    chk("t7_gid_c1", 32'(bus.grant_id), 0);
    step();
    bus.reqs = 4'b0010;
    #1;
    chk("t7_drop_grants", 32'(bus.grants), 32'h2);
    step();
    bus.reqs = 4'b0011;
    #1;
    chk("t7_after", 32'(bus.grants), 32'h1);

    // weight 0 behaves as 1
    do_reset();
    weights  = 16'h0000;
    bus.reqs = 4'b0011;
    #1;
    chk("t8_gid0", 32'(bus.grant_id), 0);
    step();
    chk("t8_gid1", 32'(bus.grant_id), 1);
    step();
    chk("t8_gid2", 32'(bus.grant_id), 0);

    // lock protocol error, then async reset mid-packet
    do_reset();
    weights   = 16'h1111;
    bus.reqs  = 4'b0100;
    bus.locks = 4'b0100;
    #1;
    chk("t6_grants_c1", 32'(bus.grants), 32'h4);
    step();
    chk("t6_locked_c2", 32'(bus.locked), 1);
    bus.reqs = 4'b0001;
    #1;
    chk("t6_err_grants", 32'(bus.grants), 0);
    chk("t6_err_xfer",   32'(bus.xfer), 0);
    step();
    chk("t6_err_locked", 32'(bus.locked), 1);
    bus.reqs = 4'b0101;
    #1;
    chk("t6_grants_lock", 32'(bus.grants), 32'h4);
    reset = 1'b0;
    #1;
    chk("t6_rst_locked", 32'(bus.locked), 0);
    chk("t6_rst_grants", 32'(bus.grants), 32'h1);
    bus.locks = '0;
    step();
    reset = 1'b1;
    #1;
    chk("t6_rr0", 32'(bus.grant_id), 0);
    step();
    chk("t6_rr1", 32'(bus.grant_id), 2);
    step();
    chk("t6_rr2", 32'(bus.grant_id), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
